iq_sample_pacer: RTL and testbench
==================================

# iq_sample_pacer

Read-side scheduler for the IQ sample FIFO. The SPI controller writes interleaved I/Q bytes into the FIFO. This block drains the FIFO in I-then-Q byte pairs and presents one complex sample per programmable sample period to the modulator/DAC path. It also pre-fetches the next pair and flags underflow when the FIFO cannot keep up.

## Interface
Parameters:
- DIV_W, 16, width of the sample-period divider.
- MIN_DIV, 4, smallest effective divider; covers the 4-cycle pair fetch.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  run request from configuration logic.
- rate_div  in  DIV_W  sample period minus one, in clk cycles.
- fifo_rd  out  1  FIFO read strobe.
- fifo_data_out  in  8  FIFO read data, valid the cycle after fifo_rd (no show-ahead).
- fifo_empty  in  1  FIFO empty flag.
- i_out  out  8  I sample.
- q_out  out  8  Q sample.
- sample_valid  out  1  one-cycle pulse per sample period.
- underflow  out  1  one-cycle pulse: a sample tick found no staged pair.
- underflow_count  out  16  saturating underflow tally (see Configuration).

## Operation
- Effective divider: div_eff = max(rate_div, MIN_DIV). rate_div is sampled when a period reloads, so changes take effect at the next period boundary.
- Tick counter loads div_eff, decrements each cycle while running, and raises tick at 0, then reloads. Period = div_eff+1 cycles.
- States:
  - S_IDLE: counter held, no reads. On enable, go to S_RD_I and load the counter.
  - S_RD_I: if !fifo_empty, assert fifo_rd and go to S_LAT_I; otherwise wait here.
  - S_LAT_I: capture I byte into the staging register, then go to S_RD_Q.
  - S_RD_Q: if !fifo_empty, assert fifo_rd and go to S_LAT_Q; otherwise wait here, keeping the I byte.
  - S_LAT_Q: capture the Q byte and set staged=1. Go to S_HOLD.
  - S_HOLD: wait for tick.
- On tick:
  - If staged: i_out/q_out <= staging, sample_valid=1, staged=0. The FSM goes to S_RD_I, or to S_IDLE if enable=0.
  - If not staged: i_out=q_out=0, sample_valid=1, underflow=1. The fetch in progress continues, and its pair is used at the next tick.
- enable deasserted mid-pair: the pair completes, then the FSM stops (S_HOLD goes to S_IDLE without outputting). The FIFO byte alignment is never broken by disable.
- fifo_rd is never asserted while fifo_empty=1.

## Timing
- Reset values: fifo_rd=0, i_out=0, q_out=0, sample_valid=0, underflow=0, underflow_count=0, state=S_IDLE, staged=0, counter=0.
- First sample_valid arrives div_eff+1 cycles after the cycle in which enable is seen in S_IDLE.
- Pair fetch on a non-empty FIFO takes 4 cycles, which is ≤ MIN_DIV+1. A steady stream therefore never underflows.
- sample_valid, underflow and fifo_rd are single-cycle pulses. Outputs change only on the sample_valid cycle.
- rst mid-fetch: an immediate return to reset values. FIFO realignment is the host's job (flush).

## Configuration
- IQ_UNDERFLOW_CNT_EN defined: underflow_count increments on each underflow pulse, saturates at 16'hFFFF, and clears only on rst.
- IQ_UNDERFLOW_CNT_EN undefined: the counter logic is omitted and underflow_count is tied to 0. The underflow pulse is unaffected.

## Structure
- Shared package: state encodings (S_IDLE, S_RD_I, S_LAT_I, S_RD_Q, S_LAT_Q, S_HOLD) and the MIN_DIV default.
- Sub-module rate_tick_gen: divider counter with clamp, reload and tick output, and a run input. The FSM and staging registers stay in the top module.

## Test plan
- FIFO preloaded with 01,02,03,04, rate_div=9, enable=1 -> sample_valid at cycle 10 with (01,02), at cycle 20 with (03,04); no underflow.
- rate_div=1 -> period clamps to 5 cycles; continuous stream, zero underflows.
- FIFO empty at enable, rate_div=9 -> first tick gives (00,00) with underflow=1. Bytes AA,BB written at cycle 12 -> next tick outputs (AA,BB).
- FIFO holds only I byte 11, Q byte 22 written 30 cycles later -> fifo_rd never pulses while empty; output pairs as (11,22), not misaligned.
- enable dropped in S_RD_Q -> the pair completes, no sample_valid follows, FSM in S_IDLE, and exactly 2 reads occur.
- With IQ_UNDERFLOW_CNT_EN, 3 consecutive empty ticks -> underflow_count=3. Without the macro -> stays 0.

Source files
------------

// File: rtl/iq_sample_pacer_pkg.sv
// Shared definitions for the IQ sample pacer: FSM state encoding and divider floor.
package iq_sample_pacer_pkg;

    // A pair fetch needs 4 cycles, so the period must never drop below 5 cycles.
    localparam int unsigned MIN_DIV_DEFAULT = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_I  = 3'd1,
        S_LAT_I = 3'd2,
        S_RD_Q  = 3'd3,
        S_LAT_Q = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

endpackage

// File: rtl/iq_sample_pacer_rate_tick_gen.sv
// Sample-period divider: clamps the programmed divider, reloads each period and
// raises a one-cycle tick when the count reaches zero.
module iq_sample_pacer_rate_tick_gen
    import iq_sample_pacer_pkg::*;
#(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned MIN_DIV = MIN_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_rate_div,
    output logic             o_tick
);

    localparam logic [DIV_W-1:0] MinDivW = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] OneW    = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_div_eff;

    assign w_div_eff = (i_rate_div < MinDivW) ? MinDivW : i_rate_div;
    assign o_tick    = i_run && (r_cnt == '0);

    // Counter: the start cycle already counts as the first cycle of the period,
    // so the first tick lands div_eff cycles after start, later ones every div_eff+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= w_div_eff - OneW;
        end else if (i_run) begin
            r_cnt <= (r_cnt == '0) ? w_div_eff : r_cnt - OneW;
        end
    end

endmodule

// File: rtl/iq_sample_pacer.sv
// Read-side scheduler for the IQ sample FIFO: fetches I/Q byte pairs, stages
// one pair ahead and presents it once per sample period.
// Optional feature: define IQ_UNDERFLOW_CNT_EN to build the saturating underflow tally.
module iq_sample_pacer
    import iq_sample_pacer_pkg::*;
#(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned MIN_DIV = MIN_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic [DIV_W-1:0] i_rate_div,
    output logic             o_fifo_rd,
    input  logic [7:0]       i_fifo_data_out,
    input  logic             i_fifo_empty,
    output logic [7:0]       o_i_out,
    output logic [7:0]       o_q_out,
    output logic             o_sample_valid,
    output logic             o_underflow,
    output logic [15:0]      o_underflow_count
);

    state_t     r_state;
    state_t     w_state_next;
    logic       w_tick;
    logic       w_start;
    logic       w_run;
    logic       w_fifo_rd;
    logic       w_cap_i;
    logic       w_cap_q;
    logic       w_pair_ready;
    logic       w_underflow_evt;
    logic [7:0] w_pair_q;

    logic [7:0] r_stage_i;
    logic [7:0] r_stage_q;
    logic       r_staged;
    logic [7:0] r_i_out;
    logic [7:0] r_q_out;
    logic       r_sample_valid;
    logic       r_underflow;

    assign w_start = (r_state == S_IDLE) && i_enable;
    assign w_run   = (r_state != S_IDLE);

    iq_sample_pacer_rate_tick_gen #(
        .DIV_W   (DIV_W),
        .MIN_DIV (MIN_DIV)
    ) u_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_run      (w_run),
        .i_rate_div (i_rate_div),
        .o_tick     (w_tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; once an I byte is read the pair always completes.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (i_enable) w_state_next = S_RD_I;
            S_RD_I: begin
                // No byte of this pair consumed yet, so stopping keeps alignment.
                if (!i_enable) w_state_next = S_IDLE;
                else if (!i_fifo_empty) w_state_next = S_LAT_I;
            end
            S_LAT_I: w_state_next = S_RD_Q;
            S_RD_Q:  if (!i_fifo_empty) w_state_next = S_LAT_Q;
            S_LAT_Q: begin
                if (w_tick) w_state_next = i_enable ? S_RD_I : S_IDLE;
                else        w_state_next = S_HOLD;
            end
            S_HOLD: begin
                if (w_tick || !i_enable) w_state_next = i_enable ? S_RD_I : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: read strobe and staging captures.
    always_comb begin
        w_fifo_rd = 1'b0;
        w_cap_i   = 1'b0;
        w_cap_q   = 1'b0;
        unique case (r_state)
            S_RD_I:  w_fifo_rd = i_enable && !i_fifo_empty;
            S_LAT_I: w_cap_i = 1'b1;
            S_RD_Q:  w_fifo_rd = !i_fifo_empty;
            S_LAT_Q: w_cap_q = 1'b1;
            default: ;
        endcase
    end

    // A tick in S_LAT_Q takes the Q byte straight off the FIFO data bus.
    assign w_pair_ready    = r_staged || w_cap_q;
    assign w_pair_q        = r_staged ? r_stage_q : i_fifo_data_out;
    assign w_underflow_evt = w_tick && !w_pair_ready;

    // Staging registers and sample outputs; outputs only move on a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_i      <= '0;
            r_stage_q      <= '0;
            r_staged       <= 1'b0;
            r_i_out        <= '0;
            r_q_out        <= '0;
            r_sample_valid <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_sample_valid <= w_tick;
            r_underflow    <= w_underflow_evt;
            if (w_tick) begin
                r_i_out <= w_pair_ready ? r_stage_i : 8'h00;
                r_q_out <= w_pair_ready ? w_pair_q : 8'h00;
            end
            if (w_cap_i) r_stage_i <= i_fifo_data_out;
            if (w_cap_q) r_stage_q <= i_fifo_data_out;
            // A pair left staged when stopping is dropped.
            if (w_state_next == S_IDLE || (w_tick && w_pair_ready)) begin
                r_staged <= 1'b0;
            end else if (w_cap_q) begin
                r_staged <= 1'b1;
            end
        end
    end

`ifdef IQ_UNDERFLOW_CNT_EN
    logic [15:0] r_underflow_count;

    // Saturating tally, updated alongside the underflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_underflow_count <= '0;
        end else if (w_underflow_evt && (r_underflow_count != 16'hFFFF)) begin
            r_underflow_count <= r_underflow_count + 16'd1;
        end
    end

    assign o_underflow_count = r_underflow_count;
`else
    assign o_underflow_count = '0;
`endif

    assign o_fifo_rd      = w_fifo_rd;
    assign o_i_out        = r_i_out;
    assign o_q_out        = r_q_out;
    assign o_sample_valid = r_sample_valid;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_iq_sample_pacer.sv
// Directed bench for iq_sample_pacer with a behavioural no-show-ahead FIFO.
module tb_iq_sample_pacer;
    import iq_sample_pacer_pkg::*;

`ifdef IQ_UNDERFLOW_CNT_EN
    localparam int unsigned ExpUfCount = 3;
`else
    localparam int unsigned ExpUfCount = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] rate_div;
    logic        fifo_rd;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic [7:0]  i_out;
    logic [7:0]  q_out;
    logic        sample_valid;
    logic        underflow;
    logic [15:0] underflow_count;

    int n_cmp = 0;
    int n_err = 0;

    // FIFO model: writer bumps wr_ptr at negedges, reader pops at posedges.
    logic [7:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_cnt = 0;
    int rd_empty_cnt = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    iq_sample_pacer dut (
        .clk               (clk),
        .rst               (rst),
        .i_enable          (enable),
        .i_rate_div        (rate_div),
        .o_fifo_rd         (fifo_rd),
        .i_fifo_data_out   (fifo_dout),
        .i_fifo_empty      (fifo_empty),
        .o_i_out           (i_out),
        .o_q_out           (q_out),
        .o_sample_valid    (sample_valid),
        .o_underflow       (underflow),
        .o_underflow_count (underflow_count)
    );

    // Reset flushes the model FIFO and the read statistics.
    always @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= wr_ptr;
            rd_cnt       <= 0;
            rd_empty_cnt <= 0;
        end else if (fifo_rd) begin
            rd_cnt <= rd_cnt + 1;
            if (wr_ptr == rd_ptr) begin
                rd_empty_cnt <= rd_empty_cnt + 1;
            end else begin
                fifo_dout <= mem[rd_ptr % 64];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] rate_div;
        logic [31:0] bytes;   // FIFO preload, first byte in [31:24]
        int          t1;      // cycle of first sample_valid
        int          t2;      // cycle of second sample_valid
    } vec_t;

    vec_t vecs [5];

    initial begin
        int p1c, p2c, ufs, pulses;
        logic [15:0] p1, p2, last;

        vecs[0] = '{rate_div: 16'd9, bytes: 32'h01020304, t1: 10, t2: 20};
        vecs[1] = '{rate_div: 16'd1, bytes: 32'hA55AFF00, t1: 5,  t2: 10};
        vecs[2] = '{rate_div: 16'd0, bytes: 32'h12345678, t1: 5,  t2: 10};
        vecs[3] = '{rate_div: 16'd4, bytes: 32'hDEADBEEF, t1: 5,  t2: 10};
        vecs[4] = '{rate_div: 16'd6, bytes: 32'h80017F02, t1: 7,  t2: 14};

        rate_div = 16'd9;
        do_reset();
        chk("reset_iq", {16'h0, i_out, q_out}, 32'h0);
        chk("reset_pulses", {29'h0, sample_valid, underflow, fifo_rd}, 32'h0);
        chk("reset_ufcnt", {16'h0, underflow_count}, 32'h0);

        // Two-sample steady streams from a preloaded FIFO.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            rate_div = vecs[v].rate_div;
            for (int k = 3; k >= 0; k--) push(vecs[v].bytes[k*8 +: 8]);
            enable = 1'b1;
            p1c = -1; p2c = -1; p1 = '0; p2 = '0; ufs = 0;
            for (int c = 1; c <= vecs[v].t2 + 2; c++) begin
                @(negedge clk);
                if (sample_valid) begin
                    if (p1c < 0) begin
                        p1c = c; p1 = {i_out, q_out};
                    end else if (p2c < 0) begin
                        p2c = c; p2 = {i_out, q_out};
                    end
                end
                if (underflow) ufs++;
            end
            chk($sformatf("v%0d_t1", v), 32'(p1c), 32'(vecs[v].t1));
            chk($sformatf("v%0d_pair1", v), {16'h0, p1}, {16'h0, vecs[v].bytes[31:16]});
            chk($sformatf("v%0d_t2", v), 32'(p2c), 32'(vecs[v].t2));
            chk($sformatf("v%0d_pair2", v), {16'h0, p2}, {16'h0, vecs[v].bytes[15:0]});
            chk($sformatf("v%0d_uf", v), 32'(ufs), 32'd0);
            chk($sformatf("v%0d_reads", v), 32'(rd_cnt), 32'd4);
        end

        // Longer clamped stream: six samples at period 5, never underflows.
        do_reset();
        rate_div = 16'd1;
        for (int k = 0; k < 12; k++) push(8'(8'h10 + k));
        enable = 1'b1;
        pulses = 0; ufs = 0; last = '0;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            if (sample_valid) begin
                pulses++; last = {i_out, q_out};
            end
            if (underflow) ufs++;
        end
        chk("stream_pulses", 32'(pulses), 32'd6);
        chk("stream_uf", 32'(ufs), 32'd0);
        chk("stream_last", {16'h0, last}, 32'h1A1B);

        // Empty at start: first tick underflows, late pair goes out on the next tick.
        do_reset();
        rate_div = 16'd9;
        enable = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (sample_valid) pulses++;
            if (c == 12) begin
                push(8'hAA);
                push(8'hBB);
            end
            if (c == 10) begin
                chk("uf_tick_flags", {30'h0, sample_valid, underflow}, 32'h3);
                chk("uf_tick_iq", {16'h0, i_out, q_out}, 32'h0);
            end
            if (c == 20) begin
                chk("late_pair_flags", {30'h0, sample_valid, underflow}, 32'h2);
                chk("late_pair_iq", {16'h0, i_out, q_out}, 32'hAABB);
            end
        end
        chk("uf_pulses", 32'(pulses), 32'd2);
        chk("uf_rd_empty", 32'(rd_empty_cnt), 32'd0);

        // Lone I byte, Q arrives much later: stays aligned, three underflow ticks.
        do_reset();
        rate_div = 16'd9;
        push(8'h11);
        enable = 1'b1;
        ufs = 0; p1c = -1; p1 = '0;
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            if (c == 33) push(8'h22);
            if (underflow) ufs++;
            if (sample_valid && !underflow && p1c < 0) begin
                p1c = c; p1 = {i_out, q_out};
            end
            if (c == 31) chk("ufcnt_after_3", {16'h0, underflow_count}, 32'(ExpUfCount));
        end
        chk("align_uf", 32'(ufs), 32'd3);
        chk("align_t", 32'(p1c), 32'd40);
        chk("align_pair", {16'h0, p1}, 32'h1122);
        chk("align_reads", 32'(rd_cnt), 32'd2);
        chk("align_rd_empty", 32'(rd_empty_cnt), 32'd0);
        chk("ufcnt_hold", {16'h0, underflow_count}, 32'(ExpUfCount));

        // Disable while waiting to read Q: pair completes, then silence.
        do_reset();
        rate_div = 16'd9;
        for (int k = 1; k <= 4; k++) push(8'(k));
        enable = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 3) begin
                chk("dis_in_rd_q", 32'(dut.r_state), 32'(S_RD_Q));
                enable = 1'b0;
            end
            if (sample_valid) pulses++;
        end
        chk("dis_pulses", 32'(pulses), 32'd0);
        chk("dis_reads", 32'(rd_cnt), 32'd2);
        chk("dis_idle", 32'(dut.r_state), 32'(S_IDLE));

        // Reset mid-fetch right after a non-zero sample.
        do_reset();
        rate_div = 16'd4;
        push(8'h5C); push(8'hC5); push(8'h01); push(8'h02);
        enable = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 5) chk("pre_rst_iq", {16'h0, i_out, q_out}, 32'h5CC5);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_iq", {16'h0, i_out, q_out}, 32'h0);
        chk("midrst_pulses", {29'h0, sample_valid, underflow, fifo_rd}, 32'h0);
        chk("midrst_state", 32'(dut.r_state), 32'(S_IDLE));
        chk("midrst_staged", {31'h0, dut.r_staged}, 32'h0);
        rst = 1'b0;
        enable = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
